spi64_xfer_queue: RTL and testbench

- Upstream command/response stage for the 64-bit SPI master wrapper (start/status/out/in interface).
- Buffers outgoing 64-bit words in a TX FIFO and launches one wrapper transfer per word.
- Captures each received 64-bit word into an RX FIFO, exposed to the consumer through valid/ready.
- Provides back-pressure, in-flight tracking and a sticky timeout flag if the wrapper stalls.

---
 rtl/spi64_pkg.sv | 21 ++
 rtl/spi64_xfer_queue_if.sv | 37 +++
 rtl/spi64_sync_fifo.sv | 56 +++++
 rtl/spi64_xfer_queue.sv | 140 ++++++++++++++
 tb/tb_spi64_xfer_queue.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi64_pkg.sv
// Shared types and constants for the 64-bit SPI transfer queue.
package spi64_pkg;

  localparam int unsigned SPI64_W                = 64;
  localparam int unsigned SPI64_DEPTH_DEF        = 4;
  localparam int unsigned SPI64_ACK_TIMEOUT_DEF  = 16;
  localparam int unsigned SPI64_DONE_TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } xfer_state_e;

  // Timer width able to hold the larger of the two timeout limits.
  function automatic int unsigned timer_bits(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/spi64_xfer_queue_if.sv
// Handshake, wrapper and status signals of the SPI transfer queue.
interface spi64_xfer_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import spi64_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [SPI64_W-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [SPI64_W-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               spi_start;
  logic [SPI64_W-1:0] spi_out;
  logic [SPI64_W-1:0] spi_in;
  logic               spi_status;
  logic               busy;
  logic               err_timeout;
  logic [LW-1:0]      tx_level;
  logic [LW-1:0]      rx_level;

  // Environment side: producer, consumer and the SPI wrapper.
  modport master (
    output tx_data, tx_valid, rx_ready, spi_in, spi_status,
    input  tx_ready, rx_data, rx_valid, spi_start, spi_out,
           busy, err_timeout, tx_level, rx_level
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, spi_in, spi_status,
    output tx_ready, rx_data, rx_valid, spi_start, spi_out,
           busy, err_timeout, tx_level, rx_level
  );

endinterface

// File: rtl/spi64_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module spi64_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/spi64_xfer_queue.sv
// TX/RX word queues around the 64-bit SPI wrapper with credit-based launch and abort timers.
module spi64_xfer_queue
  import spi64_pkg::*;
#(
  parameter int unsigned DEPTH        = SPI64_DEPTH_DEF,
  parameter int unsigned ACK_TIMEOUT  = SPI64_ACK_TIMEOUT_DEF,
  parameter int unsigned DONE_TIMEOUT = SPI64_DONE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  spi64_xfer_queue_if.slave bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = timer_bits(ACK_TIMEOUT, DONE_TIMEOUT);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);

  xfer_state_e        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic               in_flight_q, in_flight_d;
  logic               err_q, err_d;
  logic [SPI64_W-1:0] spi_out_q, spi_out_d;

  logic [SPI64_W-1:0] tx_head, rx_head;
  logic               tx_full, tx_empty, tx_push, tx_pop;
  logic               rx_full, rx_empty, rx_push, rx_wr;
  logic [LW-1:0]      tx_level, rx_level;
  logic               credit_ok, spi_start;

  // Ready also while full if the FSM pops this cycle, so push+pop at full keeps the level.
  assign tx_push = bus.tx_valid && (!tx_full || tx_pop);
  assign rx_wr   = rx_push && !rx_full;

  spi64_sync_fifo #(.WIDTH(SPI64_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (tx_push),
    .wr_data_i (bus.tx_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .level_o   (tx_level)
  );

  spi64_sync_fifo #(.WIDTH(SPI64_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (rx_wr),
    .wr_data_i (bus.spi_in),
    .rd_en_i   (bus.rx_ready),
    .rd_data_o (rx_head),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .level_o   (rx_level)
  );

  assign credit_ok = ((LW+1)'(rx_level) + (LW+1)'(in_flight_q)) < (LW+1)'(DEPTH);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    in_flight_d = in_flight_q;
    err_d       = err_q;
    spi_out_d   = spi_out_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    spi_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && credit_ok) begin
          spi_out_d   = tx_head;
          tx_pop      = 1'b1;
          in_flight_d = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        spi_start = 1'b1;
        timer_d   = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.spi_status) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q >= ACK_LAST) begin
          err_d       = 1'b1;
          in_flight_d = 1'b0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_DONE: begin
        if (!bus.spi_status) begin
          rx_push     = 1'b1;
          in_flight_d = 1'b0;
          state_d     = IDLE;
        end else if (timer_q >= DONE_LAST) begin
          err_d       = 1'b1;
          in_flight_d = 1'b0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      in_flight_q <= 1'b0;
      err_q       <= 1'b0;
      spi_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
      spi_out_q   <= spi_out_d;
    end
  end

  assign bus.tx_ready    = !tx_full || tx_pop;
  assign bus.rx_data     = rx_head;
  assign bus.rx_valid    = !rx_empty;
  assign bus.spi_start   = spi_start;
  assign bus.spi_out     = spi_out_q;
  assign bus.busy        = (state_q != IDLE) || !tx_empty;
  assign bus.err_timeout = err_q;
  assign bus.tx_level    = tx_level;
  assign bus.rx_level    = rx_level;

endmodule

// File: tb/tb_spi64_xfer_queue.sv
// Scoreboard bench for spi64_xfer_queue with a behavioural SPI wrapper model.
module tb_spi64_xfer_queue;

  localparam int unsigned DEPTH = 4;

  typedef enum int unsigned {W_NOACK, W_FIXED, W_LOOP} wmode_e;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spi64_xfer_queue_if #(.DEPTH(DEPTH)) bus ();

  spi64_xfer_queue #(
    .DEPTH        (DEPTH),
    .ACK_TIMEOUT  (16),
    .DONE_TIMEOUT (4096)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned launches = 0;
  logic [63:0] exp_launch[$];
  logic [63:0] exp_rx[$];

  wmode_e      w_mode  = W_LOOP;
  int unsigned w_busy  = 3;
  logic [63:0] w_fixed = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=%h required=none", name, act);
  endfunction

  task automatic drive_phase();
    @(posedge clk);
    #1;
  endtask

  // Holds tx_valid until a handshake; reports the TX level seen in the accepting cycle.
  task automatic push(input logic [63:0] d, output logic [2:0] lvl);
    bit acc;
    acc = 1'b0;
    lvl = '0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = bus.tx_ready;
      lvl = bus.tx_level;
      @(posedge clk);
      #1;
    end
    bus.tx_valid = 1'b0;
    check("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_launch.size() == 0) && (exp_rx.size() == 0) && !bus.busy && !bus.rx_valid;
    end
    check({name, "_drain"}, 64'(done), 64'd1);
    drive_phase();
  endtask

  // Launch monitor: every spi_start must match the next queued word.
  initial forever begin
    @(negedge clk);
    if (bus.spi_start) begin
      launches++;
      check("start_while_status", 64'(bus.spi_status), 64'd0);
      if (exp_launch.size() == 0) unexpected("unexpected_launch", bus.spi_out);
      else check("launch_word", bus.spi_out, exp_launch.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.rx_valid && bus.rx_ready) begin
      if (exp_rx.size() == 0) unexpected("unexpected_rx", bus.rx_data);
      else check("rx_word", bus.rx_data, exp_rx.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && !bus.tx_ready) check("tx_ready_low_level", 64'(bus.tx_level), 64'd4);
  end

  // Wrapper model: status rises the cycle after start, falls w_busy cycles later with spi_in.
  initial begin
    logic        s_start, s_rst, w_active;
    logic [63:0] s_out, w_resp;
    int unsigned w_cnt;
    w_active = 1'b0;
    w_cnt    = 0;
    w_resp   = '0;
    forever begin
      @(negedge clk);
      s_start = bus.spi_start;
      s_out   = bus.spi_out;
      s_rst   = reset;
      @(posedge clk);
      #1;
      if (s_rst) begin
        w_active       = 1'b0;
        bus.spi_status = 1'b0;
      end else if (w_active) begin
        if (w_cnt == 0) begin
          bus.spi_status = 1'b0;
          bus.spi_in     = w_resp;
          w_active       = 1'b0;
        end else begin
          w_cnt--;
        end
      end else if (s_start && w_mode != W_NOACK) begin
        bus.spi_status = 1'b1;
        w_cnt          = w_busy - 1;
        w_resp         = (w_mode == W_LOOP) ? s_out + 64'd1 : w_fixed;
        w_active       = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  lvl;
    int unsigned l0;
    logic [63:0] t2_tx [4] = '{64'h1, 64'h2, 64'h3, 64'h4};
    logic [63:0] t2_rx [4] = '{64'h2, 64'h3, 64'h4, 64'h5};
    logic [63:0] t3_tx [6] = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15};
    logic [63:0] t3_rx [6] = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16};
    logic [63:0] t6_tx [6] = '{64'h61, 64'h62, 64'h63, 64'h64, 64'h65, 64'h66};
    logic [63:0] t6_rx [6] = '{64'h62, 64'h63, 64'h64, 64'h65, 64'h66, 64'h67};

    bus.tx_data    = '0;
    bus.tx_valid   = 1'b0;
    bus.rx_ready   = 1'b0;
    bus.spi_in     = '0;
    bus.spi_status = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_spi_start", 64'(bus.spi_start), 64'd0);
    check("rst_spi_out", bus.spi_out, 64'd0);
    check("rst_tx_ready", 64'(bus.tx_ready), 64'd1);
    check("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_tx_level", 64'(bus.tx_level), 64'd0);
    check("rst_rx_level", 64'(bus.rx_level), 64'd0);
    check("rst_err", 64'(bus.err_timeout), 64'd0);
    drive_phase();

    // Single word through a 40-cycle busy wrapper.
    w_mode  = W_FIXED;
    w_fixed = 64'hFEDCBA9876543210;
    w_busy  = 40;
    exp_launch.push_back(64'h0123456789ABCDEF);
    push(64'h0123456789ABCDEF, lvl);
    @(negedge clk);
    check("t1_start_n1", 64'(bus.spi_start), 64'd0);
    @(negedge clk);
    check("t1_start_n2", 64'(bus.spi_start), 64'd1);
    @(negedge clk);
    check("t1_start_pulse", 64'(bus.spi_start), 64'd0);
    check("t1_out_hold", bus.spi_out, 64'h0123456789ABCDEF);
    check("t1_status_up", 64'(bus.spi_status), 64'd1);
    repeat (40) @(negedge clk);
    check("t1_status_down", 64'(bus.spi_status), 64'd0);
    check("t1_rx_not_yet", 64'(bus.rx_valid), 64'd0);
    @(negedge clk);
    check("t1_rx_valid", 64'(bus.rx_valid), 64'd1);
    check("t1_rx_data", bus.rx_data, 64'hFEDCBA9876543210);
    check("t1_rx_level", 64'(bus.rx_level), 64'd1);
    exp_rx.push_back(64'hFEDCBA9876543210);
    drive_phase();
    bus.rx_ready = 1'b1;
    wait_drain("t1");

    // Burst with loopback wrapper.
    w_mode = W_LOOP;
    w_busy = 3;
    l0 = launches;
    for (int i = 0; i < 4; i++) begin
      exp_launch.push_back(t2_tx[i]);
      exp_rx.push_back(t2_rx[i]);
      push(t2_tx[i], lvl);
    end
    wait_drain("t2");
    check("t2_launches", 64'(launches - l0), 64'd4);

    // Back-pressure: RX held, only DEPTH transfers may launch.
    bus.rx_ready = 1'b0;
    l0 = launches;
    for (int i = 0; i < 6; i++) begin
      exp_launch.push_back(t3_tx[i]);
      exp_rx.push_back(t3_rx[i]);
      push(t3_tx[i], lvl);
    end
    repeat (60) @(negedge clk);
    check("t3_launches_held", 64'(launches - l0), 64'd4);
    check("t3_rx_level", 64'(bus.rx_level), 64'd4);
    check("t3_tx_level", 64'(bus.tx_level), 64'd2);
    check("t3_busy", 64'(bus.busy), 64'd1);
    drive_phase();
    bus.rx_ready = 1'b1;
    wait_drain("t3");
    check("t3_launches_all", 64'(launches - l0), 64'd6);

    // ACK timeout drops the first word; the second then completes.
    w_mode = W_NOACK;
    exp_launch.push_back(64'hA5A5A5A5A5A5A5A5);
    exp_launch.push_back(64'h5A5A5A5A5A5A5A5A);
    exp_rx.push_back(64'h5A5A5A5A5A5A5A5B);
    push(64'hA5A5A5A5A5A5A5A5, lvl);
    push(64'h5A5A5A5A5A5A5A5A, lvl);
    @(negedge clk);
    check("t4_start", 64'(bus.spi_start), 64'd1);
    repeat (15) @(negedge clk);
    check("t4_err_early", 64'(bus.err_timeout), 64'd0);
    w_mode = W_LOOP;
    repeat (2) @(negedge clk);
    check("t4_err_set", 64'(bus.err_timeout), 64'd1);
    drive_phase();
    wait_drain("t4");
    check("t4_err_sticky", 64'(bus.err_timeout), 64'd1);

    // Reset while in WAIT_DONE with two words queued.
    w_mode  = W_FIXED;
    w_busy  = 40;
    w_fixed = 64'hDEADBEEFDEADBEEF;
    exp_launch.push_back(64'hC0);
    push(64'hC0, lvl);
    push(64'hD0, lvl);
    push(64'hE0, lvl);
    repeat (8) @(negedge clk);
    check("t5_pre_tx_level", 64'(bus.tx_level), 64'd2);
    check("t5_pre_status", 64'(bus.spi_status), 64'd1);
    drive_phase();
    reset = 1'b1;
    drive_phase();
    reset = 1'b0;
    @(negedge clk);
    check("t5_spi_start", 64'(bus.spi_start), 64'd0);
    check("t5_tx_level", 64'(bus.tx_level), 64'd0);
    check("t5_rx_level", 64'(bus.rx_level), 64'd0);
    check("t5_err", 64'(bus.err_timeout), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd0);
    l0 = launches;
    repeat (50) @(negedge clk);
    check("t5_no_launch", 64'(launches - l0), 64'd0);
    check("t5_rx_empty", 64'(bus.rx_valid), 64'd0);
    drive_phase();

    // Push and pop on a full TX FIFO in the same cycle.
    w_mode = W_LOOP;
    w_busy = 10;
    for (int i = 0; i < 6; i++) begin
      exp_launch.push_back(t6_tx[i]);
      exp_rx.push_back(t6_rx[i]);
    end
    for (int i = 0; i < 5; i++) push(t6_tx[i], lvl);
    @(negedge clk);
    check("t6_full_level", 64'(bus.tx_level), 64'd4);
    check("t6_full_ready", 64'(bus.tx_ready), 64'd0);
    drive_phase();
    push(t6_tx[5], lvl);
    check("t6_level_at_accept", 64'(lvl), 64'd4);
    @(negedge clk);
    check("t6_level_after", 64'(bus.tx_level), 64'd4);
    drive_phase();
    wait_drain("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
